srv32_mem_arbiter: RTL
======================

# srv32_mem_arbiter

Shares one single-ported unified memory bus between the three srv32 core access channels: instruction read, data read and data write. It sits between `srv32_wrapper` and the memory/interconnect. It accepts the core's level-held requests, arbitrates with data priority and an instruction anti-starvation limit, and returns registered one-cycle acknowledges with read data. One transaction is outstanding at a time.

## Interface
- `STARVE_LIMIT`, 4: consecutive data grants allowed while an instruction request waits (1..15).
- `AW`, 32: address width.
- `clk` in 1: clock, rising edge.
- `resetb` in 1: asynchronous, active-high reset (1 = in reset).
- `imem_ready` in 1: core instruction-read request; held until `imem_valid`.
- `imem_addr` in AW: instruction address.
- `imem_valid` out 1: one-cycle instruction-read completion.
- `imem_rresp` out 1: instruction-read response status (1 = OK).
- `imem_rdata` out 32: instruction data, valid with `imem_valid`.
- `dmem_wready` in 1: data-write request; held until `dmem_wvalid`.
- `dmem_waddr` in AW: data-write address.
- `dmem_wdata` in 32: data-write data.
- `dmem_wstrb` in 4: data-write byte strobes.
- `dmem_wvalid` out 1: one-cycle write completion.
- `dmem_rready` in 1: data-read request; held until `dmem_rvalid`.
- `dmem_raddr` in AW: data-read address.
- `dmem_rvalid` out 1: one-cycle data-read completion.
- `dmem_rresp` out 1: data-read response status.
- `dmem_rdata` out 32: data-read data.
- `mem_req` out 1: bus request; held until `mem_gnt`.
- `mem_we` out 1: 1 = write.
- `mem_addr` out AW: bus address.
- `mem_wdata` out 32: bus write data.
- `mem_wstrb` out 4: bus write strobes; 0 for reads.
- `mem_gnt` in 1: bus accepts the request this cycle.
- `mem_rvalid` in 1: bus read data valid, at least one cycle after `mem_gnt`.
- `mem_rresp` in 1: bus read status.
- `mem_rdata` in 32: bus read data.

## Operation
- FSM states:
  - IDLE: evaluate requests; on any request, latch the winner's channel, address, wdata and wstrb, then go to REQ.
  - REQ: `mem_req`=1 from the latched values. On `mem_gnt`: a write goes to ACK; a read goes to RESP.
  - RESP: wait for `mem_rvalid`; capture `mem_rdata` and `mem_rresp`; go to ACK.
  - ACK: pulse the winner's `*valid` for one cycle; go to IDLE.
- Priority in IDLE is `dmem_wready` > `dmem_rready` > `imem_ready`.
  - Exception: if `imem_ready` is pending and `starve_cnt` == `STARVE_LIMIT`, the instruction read wins.
- `starve_cnt` (4-bit):
  - Increments on each data-channel grant while `imem_ready`=1. Saturates at `STARVE_LIMIT`.
  - Clears on an instruction grant, or in any IDLE cycle with `imem_ready`=0.
- The core must hold its request and inputs until acknowledged. The arbiter uses only its latched copy. A request dropped mid-transaction does not abort the bus access; its ack is still pulsed.
- The `*rdata`/`*rresp` outputs hold their last captured value between acks. They update only for the owning channel.
- `mem_addr`, `mem_wdata`, `mem_we` and `mem_wstrb` are stable throughout REQ.
- A `mem_rvalid` outside RESP is ignored.

## Timing
- All outputs are registered.
- Reset values: FSM=IDLE, `starve_cnt`=0. All `*valid`, `mem_req`, `mem_we` = 0. `mem_addr`, `mem_wdata`, `mem_wstrb`, all `*rdata`, all `*rresp` = 0.
- Reset asserted mid-transaction: immediate return to IDLE, no ack issued, in-flight bus read discarded. The bus side is reset together with the arbiter.
- Write latency with a zero-wait bus (request seen at cycle 0): `mem_req` cycles 1..gnt; `mem_gnt` at cycle 1 gives `dmem_wvalid` at cycle 2. Next IDLE evaluation at cycle 3.
- Read latency: `mem_gnt` at cycle 1 and `mem_rvalid` at cycle 2 give `*valid` at cycle 3 with data.
- Minimum turnaround: a new grant is possible every 3 cycles (write) or 4 cycles (read).
- Simultaneous requests from all three channels are resolved in a single IDLE cycle by the priority rule. Losers stay pending.
- A request that rises during REQ, RESP or ACK is considered at the next IDLE.

## Test plan
- Single instruction read, addr 0x100: `mem_gnt` on the first REQ cycle, `mem_rvalid` one cycle later with data 0x00000013 -> `imem_valid` pulses exactly 1 cycle, `imem_rdata`=0x00000013, `mem_we`=0.
- All three channels request at once, write to addr 0x2000 with data 0xDEADBEEF and wstrb 0xF -> bus sequence is write, then data read, then instruction read. `mem_wstrb`=0xF on the write only; each channel is acked once.
- `dmem_rready` held continuously with `imem_ready` pending, `STARVE_LIMIT`=4 -> exactly 4 data grants, then an instruction grant, then `starve_cnt`=0.
- Bus stalls `mem_gnt` for 5 cycles -> `mem_req` and `mem_addr` stable for all 5 cycles; no ack until after the grant.
- Reset asserted while in RESP -> next cycle: IDLE, `mem_req`=0, no `*valid`. A later `mem_rvalid` is ignored.
- Spurious `mem_rvalid` while in IDLE -> no ack and no change to `*rdata`.

Source files
------------

// File: rtl/srv32_mem_arbiter.sv
// Arbitrates instruction-read, data-read and data-write channels of the srv32 core onto one
// single-ported memory bus: data first, with a bounded wait for instruction fetches.
module srv32_mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned AW           = 32
) (
  input  logic          clk,
  input  logic          resetb,
  input  logic          imem_ready,
  input  logic [AW-1:0] imem_addr,
  output logic          imem_valid,
  output logic          imem_rresp,
  output logic [31:0]   imem_rdata,
  input  logic          dmem_wready,
  input  logic [AW-1:0] dmem_waddr,
  input  logic [31:0]   dmem_wdata,
  input  logic [3:0]    dmem_wstrb,
  output logic          dmem_wvalid,
  input  logic          dmem_rready,
  input  logic [AW-1:0] dmem_raddr,
  output logic          dmem_rvalid,
  output logic          dmem_rresp,
  output logic [31:0]   dmem_rdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic [3:0]    mem_wstrb,
  input  logic          mem_gnt,
  input  logic          mem_rvalid,
  input  logic          mem_rresp,
  input  logic [31:0]   mem_rdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [1:0] S_ACK  = 2'd3;

  localparam logic [1:0] CH_I = 2'd0;
  localparam logic [1:0] CH_R = 2'd1;
  localparam logic [1:0] CH_W = 2'd2;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [1:0] r_state;
  logic [1:0] r_chan;
  logic [3:0] r_starve_cnt;

  logic       w_any_req;
  logic [1:0] w_win;

  always_comb begin
    w_any_req = imem_ready | dmem_rready | dmem_wready;
    if (imem_ready && (r_starve_cnt == LIMIT)) begin
      w_win = CH_I;
    end else if (dmem_wready) begin
      w_win = CH_W;
    end else if (dmem_rready) begin
      w_win = CH_R;
    end else begin
      w_win = CH_I;
    end
  end

  always_ff @(posedge clk or posedge resetb) begin
    if (resetb) begin
      r_state      <= S_IDLE;
      r_chan       <= CH_I;
      r_starve_cnt <= 4'd0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= 32'd0;
      mem_wstrb    <= 4'd0;
      imem_valid   <= 1'b0;
      imem_rresp   <= 1'b0;
      imem_rdata   <= 32'd0;
      dmem_wvalid  <= 1'b0;
      dmem_rvalid  <= 1'b0;
      dmem_rresp   <= 1'b0;
      dmem_rdata   <= 32'd0;
    end else begin
      imem_valid  <= 1'b0;
      dmem_rvalid <= 1'b0;
      dmem_wvalid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_chan    <= w_win;
            mem_req   <= 1'b1;
            mem_we    <= (w_win == CH_W);
            mem_addr  <= (w_win == CH_W) ? dmem_waddr :
                         (w_win == CH_R) ? dmem_raddr : imem_addr;
            mem_wdata <= (w_win == CH_W) ? dmem_wdata : 32'd0;
            mem_wstrb <= (w_win == CH_W) ? dmem_wstrb : 4'd0;
            r_state   <= S_REQ;
            // Counter tracks data wins that bypassed a waiting fetch.
            if (w_win == CH_I) begin
              r_starve_cnt <= 4'd0;
            end else if (imem_ready && (r_starve_cnt < LIMIT)) begin
              r_starve_cnt <= r_starve_cnt + 4'd1;
            end
          end else if (!imem_ready) begin
            r_starve_cnt <= 4'd0;
          end
        end
        S_REQ: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            if (mem_we) begin
              dmem_wvalid <= 1'b1;
              r_state     <= S_ACK;
            end else begin
              r_state <= S_RESP;
            end
          end
        end
        S_RESP: begin
          if (mem_rvalid) begin
            if (r_chan == CH_I) begin
              imem_rdata <= mem_rdata;
              imem_rresp <= mem_rresp;
              imem_valid <= 1'b1;
            end else begin
              dmem_rdata  <= mem_rdata;
              dmem_rresp  <= mem_rresp;
              dmem_rvalid <= 1'b1;
            end
            r_state <= S_ACK;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
